// File: rtl/sparse_accum_array.sv
// rtl/sparse_accum_array.sv - lane-wise sparse multiply-accumulate over a Winograd transform tile
// Three-stage per-lane pipeline (operand, product, accumulate) under a tile-level FSM.
module sparse_accum_array #(
  parameter int DATA_W        = 16,
  parameter int ACC_W         = 32,
  parameter int N_ROWS        = 6,
  parameter int N_COLS        = 6,
  parameter int N_CH_MAX      = 64,
  parameter int CH_W          = 7,
  parameter int WEIGHT_ADDR_W = 12
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cfg_start,
  input  logic [CH_W-1:0]                    cfg_n_ch,
  input  logic [WEIGHT_ADDR_W-1:0]           cfg_wbase,
  output logic                               busy,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [N_ROWS*N_COLS*DATA_W-1:0]    y_in,
  input  logic [N_ROWS*N_COLS*DATA_W-1:0]    w_in,
  input  logic [N_ROWS*N_COLS-1:0]           w_mask,
  output logic [WEIGHT_ADDR_W-1:0]           weight_addr,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [N_ROWS*N_COLS*ACC_W-1:0]     u_out,
  output logic [15:0]                        skip_cnt
);

  localparam int N_LANES = N_ROWS * N_COLS;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_HOLD} state_t;

  state_t                   r_state;
  logic                     r_busy;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic [WEIGHT_ADDR_W-1:0] r_waddr;
  logic [15:0]              r_skip;
  logic [CH_W-1:0]          r_n_ch;
  logic [CH_W-1:0]          r_beat;
  logic                     r_s1_vld, r_s1_first, r_s1_last;
  logic                     r_s2_vld, r_s2_first, r_s2_last;
  logic                     r_s3_last;

  logic                     w_accept;
  logic                     w_cfg_ok;
  logic                     w_beat_last;
  logic [15:0]              w_skip_inc;
  logic [16:0]              w_skip_sum;

  assign w_accept    = in_valid && r_in_ready;
  assign w_cfg_ok    = (cfg_n_ch != '0) && (cfg_n_ch <= CH_W'(N_CH_MAX));
  assign w_beat_last = (r_beat == r_n_ch - CH_W'(1));
  assign w_skip_sum  = {1'b0, r_skip} + {1'b0, w_skip_inc};

  always_comb begin
    w_skip_inc = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (!w_mask[i]) w_skip_inc = w_skip_inc + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_waddr     <= '0;
      r_skip      <= '0;
      r_n_ch      <= '0;
      r_beat      <= '0;
      r_s1_vld    <= 1'b0;
      r_s1_first  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s2_vld    <= 1'b0;
      r_s2_first  <= 1'b0;
      r_s2_last   <= 1'b0;
      r_s3_last   <= 1'b0;
    end else begin
      // Each stage carries its own valid/first/last tags so input bubbles flow through.
      r_s1_vld   <= w_accept;
      r_s1_first <= w_accept && (r_beat == '0);
      r_s1_last  <= w_accept && w_beat_last;
      r_s2_vld   <= r_s1_vld;
      r_s2_first <= r_s1_first;
      r_s2_last  <= r_s1_vld && r_s1_last;
      r_s3_last  <= r_s2_vld && r_s2_last;

      case (r_state)
        S_IDLE: begin
          if (cfg_start && w_cfg_ok) begin
            r_n_ch     <= cfg_n_ch;
            r_waddr    <= cfg_wbase;
            r_beat     <= '0;
            r_skip     <= '0;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b1;
            r_state    <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_beat  <= r_beat + CH_W'(1);
            r_waddr <= r_waddr + WEIGHT_ADDR_W'(1);
            r_skip  <= w_skip_sum[16] ? 16'hFFFF : w_skip_sum[15:0];
            if (w_beat_last) begin
              r_in_ready <= 1'b0;
              r_state    <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (r_s3_last) begin
            r_out_valid <= 1'b1;
            r_state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    logic signed [DATA_W-1:0]   r_y;
    logic signed [DATA_W-1:0]   r_w;
    logic                       r_m;
    logic signed [ACC_W-1:0]    r_p;
    logic signed [ACC_W-1:0]    r_acc;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W:0]      w_sum;
    logic signed [ACC_W-1:0]    w_sat;

    assign w_prod = (2*DATA_W)'(r_y) * (2*DATA_W)'(r_w);
    assign w_sum  = (ACC_W+1)'(r_acc) + (ACC_W+1)'(r_p);
    // Overflow shows as a disagreement between the guard bit and the result sign bit.
    assign w_sat  = (w_sum[ACC_W] == w_sum[ACC_W-1]) ? w_sum[ACC_W-1:0]
                  : (w_sum[ACC_W] ? ACC_MIN : ACC_MAX);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_y   <= '0;
        r_w   <= '0;
        r_m   <= 1'b0;
        r_p   <= '0;
        r_acc <= '0;
      end else begin
        if (w_accept) begin
          r_m <= w_mask[l];
          if (w_mask[l]) begin
            r_y <= y_in[l*DATA_W +: DATA_W];
            r_w <= w_in[l*DATA_W +: DATA_W];
          end
        end
        if (r_s1_vld) r_p <= r_m ? ACC_W'(w_prod) : '0;
        if (r_s2_vld) r_acc <= r_s2_first ? r_p : w_sat;
      end
    end

    assign u_out[l*ACC_W +: ACC_W] = r_acc;
  end

  assign busy        = r_busy;
  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign weight_addr = r_waddr;
  assign skip_cnt    = r_skip;

endmodule

// File: tb/tb_sparse_accum_array.sv
// tb/tb_sparse_accum_array.sv - directed self-checking bench for sparse_accum_array
module tb_sparse_accum_array;
  localparam int NL = 36;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_start = 1'b0;
  logic [6:0]        cfg_n_ch = '0;
  logic [11:0]       cfg_wbase = '0;
  logic              busy;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [NL*16-1:0]  y_in = '0;
  logic [NL*16-1:0]  w_in = '0;
  logic [NL-1:0]     w_mask = '0;
  logic [11:0]       weight_addr;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [NL*32-1:0]  u_out;
  logic [15:0]       skip_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  sparse_accum_array dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_n_ch(cfg_n_ch),
    .cfg_wbase(cfg_wbase), .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
    .y_in(y_in), .w_in(w_in), .w_mask(w_mask), .weight_addr(weight_addr),
    .out_valid(out_valid), .out_ready(out_ready), .u_out(u_out), .skip_cnt(skip_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane(input int l);
    return u_out[l*32 +: 32];
  endfunction

  function automatic logic [NL*16-1:0] fill(input logic [15:0] v);
    logic [NL*16-1:0] r;
    for (int i = 0; i < NL; i++) r[i*16 +: 16] = v;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_lanes(input string tag, input logic [31:0] ev, input logic [31:0] od);
    for (int l = 0; l < NL; l++)
      chk($sformatf("%s_lane%0d", tag, l), {32'b0, lane(l)}, {32'b0, (l % 2 == 0) ? ev : od});
  endtask

  task automatic start_tile(input logic [6:0] n, input logic [11:0] base);
    cfg_start = 1'b1;
    cfg_n_ch  = n;
    cfg_wbase = base;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic send_beats(input int n, input logic [15:0] y, input logic [15:0] w,
                            input logic [NL-1:0] m);
    y_in = fill(y);
    w_in = fill(w);
    w_mask = m;
    in_valid = 1'b1;
    repeat (n) step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      step();
      cyc++;
    end
    chk({tag, "_out_valid"}, {63'b0, out_valid}, 64'd1);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [NL-1:0] all1;
    logic [NL-1:0] alt;
    logic [6:0] pat;
    int acc_beats;
    all1 = '1;
    alt  = 36'h555555555;

    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_in_ready",  {63'b0, in_ready},  64'd0);
    chk("rst_busy",      {63'b0, busy},      64'd0);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_waddr",     {52'b0, weight_addr}, 64'd0);
    chk("rst_skip",      {48'b0, skip_cnt},  64'd0);
    chk("rst_u_out0",    {32'b0, lane(0)},   64'd0);

    // Single channel, 3 * -2 on every lane, exact latency
    start_tile(7'd1, 12'h100);
    chk("t1_busy",     {63'b0, busy},     64'd1);
    chk("t1_in_ready", {63'b0, in_ready}, 64'd1);
    send_beats(1, 16'd3, 16'hFFFE, all1);
    chk("t1_in_ready_off", {63'b0, in_ready}, 64'd0);
    chk("t1_waddr", {52'b0, weight_addr}, 64'h101);
    chk("t1_skip",  {48'b0, skip_cnt}, 64'd0);
    chk("t1_ov_e1", {63'b0, out_valid}, 64'd0);
    step();
    chk("t1_ov_e2", {63'b0, out_valid}, 64'd0);
    step();
    chk("t1_ov_e3", {63'b0, out_valid}, 64'd0);
    step();
    chk("t1_ov_e4", {63'b0, out_valid}, 64'd1);
    check_lanes("t1", 32'hFFFFFFFA, 32'hFFFFFFFA);
    release_out();
    chk("t1_ov_drop", {63'b0, out_valid}, 64'd0);
    chk("t1_busy_drop", {63'b0, busy}, 64'd0);

    // Alternating mask, address wrap, then backpressure in HOLD
    start_tile(7'd4, 12'hFFE);
    send_beats(4, 16'd100, 16'd50, alt);
    chk("t2_waddr", {52'b0, weight_addr}, 64'h002);
    chk("t2_skip",  {48'b0, skip_cnt}, 64'd72);
    step();
    step();
    chk("t2_ov_early", {63'b0, out_valid}, 64'd0);
    step();
    chk("t2_ov", {63'b0, out_valid}, 64'd1);
    check_lanes("t2", 32'd20000, 32'd0);
    cfg_start = 1'b1;
    cfg_n_ch  = 7'd2;
    cfg_wbase = 12'h300;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("bp%0d_ov", i),   {63'b0, out_valid}, 64'd1);
      chk($sformatf("bp%0d_l0", i),   {32'b0, lane(0)},   64'd20000);
      chk($sformatf("bp%0d_l1", i),   {32'b0, lane(1)},   64'd0);
      chk($sformatf("bp%0d_rdy", i),  {63'b0, in_ready},  64'd0);
      chk($sformatf("bp%0d_addr", i), {52'b0, weight_addr}, 64'h002);
    end
    cfg_start = 1'b0;
    release_out();
    chk("bp_ov_drop",  {63'b0, out_valid}, 64'd0);
    chk("bp_busy",     {63'b0, busy},      64'd0);
    chk("bp_keep_l0",  {32'b0, lane(0)},   64'd20000);

    // Saturation
    start_tile(7'd3, 12'h000);
    send_beats(3, 16'h7FFF, 16'h7FFF, all1);
    wait_out("sat_pos");
    check_lanes("sat_pos", 32'h7FFFFFFF, 32'h7FFFFFFF);
    release_out();
    start_tile(7'd3, 12'h000);
    send_beats(3, 16'h8000, 16'h7FFF, all1);
    wait_out("sat_neg");
    check_lanes("sat_neg", 32'h80000000, 32'h80000000);
    release_out();
    start_tile(7'd2, 12'h000);
    send_beats(2, 16'h7FFF, 16'h7FFF, all1);
    wait_out("nosat");
    check_lanes("nosat", 32'h7FFE0002, 32'h7FFE0002);
    release_out();

    // Input bubbles
    start_tile(7'd4, 12'h010);
    y_in = fill(16'd100);
    w_in = fill(16'd50);
    w_mask = alt;
    pat = 7'b1011001;
    acc_beats = 0;
    for (int i = 6; i >= 0; i--) begin
      in_valid = pat[i];
      if (in_valid && in_ready) acc_beats++;
      step();
    end
    in_valid = 1'b0;
    chk("bub_beats", 64'(acc_beats), 64'd4);
    chk("bub_waddr", {52'b0, weight_addr}, 64'h014);
    chk("bub_skip",  {48'b0, skip_cnt}, 64'd72);
    wait_out("bub");
    check_lanes("bub", 32'd20000, 32'd0);
    release_out();

    // Reset mid-tile, then a clean tile
    start_tile(7'd4, 12'h020);
    send_beats(2, 16'd7, 16'd7, all1);
    rst = 1'b1;
    #1;
    chk("mrst_busy",  {63'b0, busy},      64'd0);
    chk("mrst_rdy",   {63'b0, in_ready},  64'd0);
    chk("mrst_ov",    {63'b0, out_valid}, 64'd0);
    chk("mrst_waddr", {52'b0, weight_addr}, 64'd0);
    chk("mrst_skip",  {48'b0, skip_cnt},  64'd0);
    chk("mrst_l0",    {32'b0, lane(0)},   64'd0);
    step();
    rst = 1'b0;
    step();
    start_tile(7'd2, 12'h030);
    send_beats(2, 16'd1, 16'd1, all1);
    wait_out("fresh");
    check_lanes("fresh", 32'd2, 32'd2);
    release_out();

    // Illegal channel counts, then the maximum legal one
    start_tile(7'd0, 12'h040);
    chk("ill0_busy", {63'b0, busy}, 64'd0);
    start_tile(7'd65, 12'h040);
    chk("ill65_busy", {63'b0, busy}, 64'd0);
    chk("ill65_rdy", {63'b0, in_ready}, 64'd0);
    start_tile(7'd64, 12'h040);
    chk("max_busy", {63'b0, busy}, 64'd1);
    send_beats(64, 16'd1, 16'd1, all1);
    chk("max_waddr", {52'b0, weight_addr}, 64'h080);
    wait_out("max");
    check_lanes("max", 32'd64, 32'd64);
    release_out();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
